// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready on both sides, 2-entry skid buffer,
// synchronous flush to a bubble, saturating count of flush-discarded entries.
module pipe_stage_skid #(
    parameter int                 DATA_W     = 16,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter int                 CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Handshake: a beat transfers on a side exactly when valid and ready are
    // both high at a rising clk edge; ready/valid here depend on state only.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic                in_fire, out_fire;
    logic [1:0]          drop_inc;
    logic [CNT_W:0]      drop_sum;

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    assign out_data = out_valid ? main_q : BUBBLE_VAL;
    assign drop_cnt = drop_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Entries lost to a flush: held but not taken downstream, plus the beat
    // accepted on the flush edge. Never underflows since out_fire implies occupancy>=1.
    assign drop_inc = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        drop_d  = drop_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
            drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush accounting,
// drop counter saturation (narrow instance) and asynchronous reset.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [7:0]  drop_cnt;

  logic        b_flush = 1'b0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_in_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [15:0] b_out_data;
  logic [1:0]  b_occupancy;
  logic [1:0]  b_drop_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(16), .BUBBLE_VAL(16'h0000), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_stage_skid #(.DATA_W(16), .BUBBLE_VAL(16'h0000), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy), .drop_cnt(b_drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                           input logic [1:0] occ, input logic rdy);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
    check({tag, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
    check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  initial begin
    logic [1:0] sat_exp [3];
    sat_exp[0] = 2'd2;
    sat_exp[1] = 2'd3;
    sat_exp[2] = 2'd3;

    // reset
    #1 rst = 1'b1;
    #2;
    check_out("reset", 1'b0, 16'h0000, 2'd0, 1'b1);
    check("reset_drop", {24'd0, drop_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // zero-bubble streaming
    in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h1111;
    step();
    check_out("stream1", 1'b1, 16'h1111, 2'd1, 1'b1);
    in_data = 16'h2222;
    step();
    check_out("stream2", 1'b1, 16'h2222, 2'd1, 1'b1);
    in_data = 16'h3333;
    step();
    check_out("stream3", 1'b1, 16'h3333, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    check_out("stream_drain", 1'b0, 16'h0000, 2'd0, 1'b1);

    // backpressure into the skid slot, then release
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA001;
    step();
    check_out("bp1", 1'b1, 16'hA001, 2'd1, 1'b1);
    in_data = 16'hA002;
    step();
    check_out("bp_full", 1'b1, 16'hA001, 2'd2, 1'b0);
    in_data = 16'hA003;
    step();
    check_out("bp_hold", 1'b1, 16'hA001, 2'd2, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("bp_rel1", 1'b1, 16'hA002, 2'd1, 1'b1);
    step();
    check_out("bp_rel2", 1'b1, 16'hA003, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    check_out("bp_drain", 1'b0, 16'h0000, 2'd0, 1'b1);

    // flush while the head is consumed: nothing dropped
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hC001;
    step();
    check_out("fc_load", 1'b1, 16'hC001, 2'd1, 1'b1);
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_out("fc_after", 1'b0, 16'h0000, 2'd0, 1'b1);
    check("fc_drop", {24'd0, drop_cnt}, 32'd0);

    // flush in ONE with head consumed and a new beat accepted: +1
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hD001;
    step();
    flush = 1'b1; in_data = 16'hD002; out_ready = 1'b1;
    #1;
    check("fd_ready_in_flush", {31'd0, in_ready}, 32'd1);
    step();
    check_out("fd_after", 1'b0, 16'h0000, 2'd0, 1'b1);
    check("fd_drop", {24'd0, drop_cnt}, 32'd1);

    // flush while FULL with input pending: beat not accepted (in_ready=0), +2
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hB001;
    step();
    in_data = 16'hB002;
    step();
    check_out("ff_full", 1'b1, 16'hB001, 2'd2, 1'b0);
    flush = 1'b1; in_data = 16'hB003;
    step();
    check_out("ff_after", 1'b0, 16'h0000, 2'd0, 1'b1);
    check("ff_drop", {24'd0, drop_cnt}, 32'd3);
    flush = 1'b0; in_valid = 1'b0;

    // asynchronous reset between edges while FULL
    in_valid = 1'b1; in_data = 16'hE001;
    step();
    in_data = 16'hE002;
    step();
    in_valid = 1'b0;
    check_out("ar_full", 1'b1, 16'hE001, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out("ar_now", 1'b0, 16'h0000, 2'd0, 1'b1);
    check("ar_drop", {24'd0, drop_cnt}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check_out("ar_post", 1'b0, 16'h0000, 2'd0, 1'b1);

    // saturation on the 2-bit counter: FULL flushes add 2 each
    check("sat_init", {30'd0, b_drop_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      b_flush = 1'b0; b_out_ready = 1'b0; b_in_valid = 1'b1;
      b_in_data = 16'($urandom_range(1, 16'hFFFF));
      step();
      b_in_data = 16'($urandom_range(1, 16'hFFFF));
      step();
      check($sformatf("sat_full%0d", k), {30'd0, b_occupancy}, 32'd2);
      b_flush = 1'b1;
      step();
      check($sformatf("sat_drop%0d", k), {30'd0, b_drop_cnt}, {30'd0, sat_exp[k]});
      check($sformatf("sat_empty%0d", k), {31'd0, b_out_valid}, 32'd0);
    end
    b_flush = 1'b0; b_in_valid = 1'b0;
    step();
    check("sat_hold", {30'd0, b_drop_cnt}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
